// File: rtl/eth_types_pkg.sv
// Shared Ethernet RX types: payload buffer entry layout and default buffer depth.
package eth_types_pkg;

    // log2 of the payload buffer depth in bytes
    localparam int unsigned PAYLOAD_BUF_ADDR_W = 11;

    // One buffer entry: payload byte plus end-of-packet flag
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } buf_entry_t;

endpackage

// File: rtl/payload_buf_ram.sv
// Simple dual-port RAM for buffer entries: one write port and one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module payload_buf_ram
    import eth_types_pkg::*;
#(
    parameter int unsigned ADDR_W = PAYLOAD_BUF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  buf_entry_t        i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output buf_entry_t        o_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    buf_entry_t r_mem [DEPTH];
    buf_entry_t r_rd_data;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds its value when not enabled
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/payload_packet_buffer.sv
// Packet buffer for the UDP payload stream: stores bytes in a circular RAM, exposes a packet
// to the consumer only once its last byte is committed, and drops packets that overflow.
module payload_packet_buffer
    import eth_types_pkg::*;
#(
    parameter int unsigned ADDR_W     = PAYLOAD_BUF_ADDR_W,
    parameter int unsigned PKT_CNT_W  = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            payload,
    input  logic                  payload_valid,
    input  logic                  payload_last,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [PKT_CNT_W-1:0]  pkts_pending,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [ADDR_W:0] FULL_OCC = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]       r_wr_ptr;
    logic [ADDR_W:0]       r_commit_ptr;
    logic [ADDR_W:0]       r_rd_ptr;
    logic                  r_dropping;
    logic                  r_out_valid;
    logic [PKT_CNT_W-1:0]  r_pkts;
    logic [DROP_CNT_W-1:0] r_drops;

    logic [ADDR_W:0] w_occ;
    logic [ADDR_W:0] w_wr_ptr_inc;
    logic            w_full;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_drop_done;
    logic            w_fetch;
    logic            w_last_hs;
    buf_entry_t      w_wr_entry;
    buf_entry_t      w_rd_entry;

    // Full is judged on pre-edge pointers; a same-cycle read does not free space
    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_occ == FULL_OCC);
    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_wr_en      = payload_valid && !r_dropping && !w_full;
    assign w_commit     = w_wr_en && payload_last;
    assign w_drop_done  = payload_valid && payload_last && (r_dropping || w_full);
    assign w_wr_entry   = {payload_last, payload};

    // Reader only ever sees [rd_ptr, commit_ptr), so partial packets stay hidden
    assign w_fetch   = (r_rd_ptr != r_commit_ptr) && (!r_out_valid || out_ready);
    assign w_last_hs = r_out_valid && out_ready && w_rd_entry.last;

    payload_buf_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_fetch),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_entry)
    );

    // Write side: append bytes, commit on last, roll back to commit point on overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_dropping   <= 1'b0;
        end else if (payload_valid) begin
            if (!r_dropping && !w_full) begin
                r_wr_ptr <= w_wr_ptr_inc;
                if (payload_last) begin
                    r_commit_ptr <= w_wr_ptr_inc;
                end
            end else if (payload_last) begin
                r_wr_ptr   <= r_commit_ptr;
                r_dropping <= 1'b0;
            end else begin
                r_dropping <= 1'b1;
            end
        end
    end

    // Read side: the RAM read register is the output data stage; track its valid here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fetch) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pending-packet counter: up on commit, down on last-byte handshake, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pkts <= '0;
        end else begin
            case ({w_commit, w_last_hs})
                2'b10: if (r_pkts != '1) r_pkts <= r_pkts + 1'b1;
                2'b01: if (r_pkts != '0) r_pkts <= r_pkts - 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating dropped-packet counter, bumped when a dropped packet's last byte arrives
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drops <= '0;
        end else if (w_drop_done && (r_drops != '1)) begin
            r_drops <= r_drops + 1'b1;
        end
    end

    // RAM read register has no reset, so mask the data while nothing is presented
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_valid ? w_rd_entry.data : 8'h00;
    assign out_last     = r_out_valid && w_rd_entry.last;
    assign pkts_pending = r_pkts;
    assign drop_count   = r_drops;

endmodule
